// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational RV32 ALU: decodes one instruction, holds the
// ALU operands for the op's latency, captures the result and hands it out over valid/ready.
module alu_issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        ALUCtrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [4:0]        rd_o,
  output logic              illegal_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_data1;
  logic [DATA_W-1:0]  r_data2;
  logic [2:0]         r_ctrl;
  logic [4:0]         r_rd;
  logic [DATA_W-1:0]  r_res;
  logic               r_illegal;

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic [6:0]         w_funct7;
  logic               w_legal;
  logic               w_is_mul;
  logic               w_imm_op;
  logic [2:0]         w_ctrl;
  logic [DATA_W-1:0]  w_data2;
  logic               w_accept;
  logic               w_unused_rs1_field;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];
  assign w_funct7 = inst_i[31:25];
  // Register operands arrive pre-read, so the rs1 index field is never needed here.
  assign w_unused_rs1_field = ^inst_i[19:15];

  always_comb begin
    w_legal  = 1'b0;
    w_is_mul = 1'b0;
    w_imm_op = 1'b0;
    w_ctrl   = 3'b000;
    if (w_opcode == 7'b0110011) begin
      case ({w_funct7, w_funct3})
        {7'b0000000, 3'b111}: begin w_legal = 1'b1; w_ctrl = 3'b000; end
        {7'b0000000, 3'b110}: begin w_legal = 1'b1; w_ctrl = 3'b001; end
        {7'b0000000, 3'b000}: begin w_legal = 1'b1; w_ctrl = 3'b010; end
        {7'b0100000, 3'b000}: begin w_legal = 1'b1; w_ctrl = 3'b110; end
        {7'b0000001, 3'b000}: begin w_legal = 1'b1; w_ctrl = 3'b101; w_is_mul = 1'b1; end
        default: ;
      endcase
    end else if (w_opcode == 7'b0010011 && w_funct3 == 3'b000) begin
      w_legal  = 1'b1;
      w_imm_op = 1'b1;
      w_ctrl   = 3'b010;
    end
  end

  assign w_data2  = w_imm_op ? {{(DATA_W-12){inst_i[31]}}, inst_i[31:20]} : rs2_data_i;
  assign w_accept = inst_valid_i && (r_state == IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept && w_legal) w_state_next = EXEC;
      EXEC: if (r_cnt == '0) w_state_next = DONE;
      DONE: if (res_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt     <= '0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_ctrl    <= '0;
      r_rd      <= '0;
      r_res     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_data1 <= rs1_data_i;
        r_data2 <= w_data2;
        r_ctrl  <= w_ctrl;
        r_rd    <= inst_i[11:7];
        r_cnt   <= w_is_mul ? CNT_W'(MUL_LAT - 1) : '0;
      end
      // Operands stay on the ALU until the count expires; result is sampled on that edge.
      if (r_state == EXEC) begin
        if (r_cnt == '0) r_res <= alu_result_i;
        else             r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign inst_ready_o = (r_state == IDLE);
  assign res_valid_o  = (r_state == DONE);
  assign data1_o      = r_data1;
  assign data2_o      = r_data2;
  assign ALUCtrl_o    = r_ctrl;
  assign res_data_o   = r_res;
  assign rd_o         = r_rd;
  assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small combinational ALU model in the loop.
module tb_alu_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [31:0] data1_o;
  logic [31:0] data2_o;
  logic [2:0]  ALUCtrl_o;
  logic [31:0] alu_result_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [31:0] res_data_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl #(.MUL_LAT(3), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o), .inst_i(inst_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
    .alu_result_i(alu_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .rd_o(rd_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference ALU the controller drives.
  always_comb begin
    case (ALUCtrl_o)
      3'b000:  alu_result_i = data1_o & data2_o;
      3'b001:  alu_result_i = data1_o | data2_o;
      3'b010:  alu_result_i = data1_o + data2_o;
      3'b110:  alu_result_i = data1_o - data2_o;
      3'b101:  alu_result_i = data1_o * data2_o;
      default: alu_result_i = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  task automatic run_op(input string name, input logic [31:0] inst, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] ectrl, input logic [31:0] ed2,
                        input logic [31:0] eres, input logic [4:0] erd, input int elat,
                        input int stall);
    int cyc;
    @(negedge clk_i);
    inst_valid_i = 1'b1; inst_i = inst; rs1_data_i = a; rs2_data_i = b;
    res_ready_i  = (stall == 0);
    @(negedge clk_i);
    inst_valid_i = 1'b0; rs1_data_i = 32'hDEAD_BEEF; rs2_data_i = 32'hBAD0_BAD0;
    chk({name, " ctrl"}, {29'd0, ALUCtrl_o}, {29'd0, ectrl});
    chk({name, " data1"}, data1_o, a);
    chk({name, " data2"}, data2_o, ed2);
    cyc = 0;
    while (!res_valid_o && cyc < 20) begin
      chk({name, " busy ready"}, {31'd0, inst_ready_o}, 32'd0);
      chk({name, " hold data1"}, data1_o, a);
      chk({name, " hold data2"}, data2_o, ed2);
      @(negedge clk_i);
      cyc++;
    end
    chk({name, " latency"}, cyc, elat);
    chk({name, " result"}, res_data_o, eres);
    chk({name, " rd"}, {27'd0, rd_o}, {27'd0, erd});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      chk({name, " stall valid"}, {31'd0, res_valid_o}, 32'd1);
      chk({name, " stall data"}, res_data_o, eres);
      chk({name, " stall rd"}, {27'd0, rd_o}, {27'd0, erd});
      chk({name, " stall ready"}, {31'd0, inst_ready_o}, 32'd0);
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    chk({name, " back idle"}, {31'd0, inst_ready_o}, 32'd1);
    chk({name, " valid drop"}, {31'd0, res_valid_o}, 32'd0);
    $display("op %s: ctrl=%b res=0x%08h rd=%0d lat=%0d", name, ALUCtrl_o, res_data_o, rd_o, cyc);
  endtask

  task automatic run_illegal(input string name, input logic [31:0] inst, input logic [2:0] prev_ctrl);
    @(negedge clk_i);
    inst_valid_i = 1'b1; inst_i = inst;
    @(negedge clk_i);
    inst_valid_i = 1'b0;
    chk({name, " pulse"}, {31'd0, illegal_o}, 32'd1);
    chk({name, " ready"}, {31'd0, inst_ready_o}, 32'd1);
    chk({name, " ctrl kept"}, {29'd0, ALUCtrl_o}, {29'd0, prev_ctrl});
    @(negedge clk_i);
    chk({name, " pulse end"}, {31'd0, illegal_o}, 32'd0);
    chk({name, " no valid"}, {31'd0, res_valid_o}, 32'd0);
    $display("illegal %s: inst=0x%08h consumed", name, inst);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst ready", {31'd0, inst_ready_o}, 32'd1);
    chk("rst valid", {31'd0, res_valid_o}, 32'd0);
    chk("rst illegal", {31'd0, illegal_o}, 32'd0);
    chk("rst ctrl", {29'd0, ALUCtrl_o}, 32'd0);
    chk("rst data", data1_o | data2_o | res_data_o, 32'd0);
    chk("rst rd", {27'd0, rd_o}, 32'd0);
    rst_i = 1'b1;

    run_op("ADD", enc_r(7'b0000000, 3'b000, 5'd3), 32'd5, 32'd7, 3'b010, 32'd7, 32'd12, 5'd3, 1, 0);
    run_op("SUB", enc_r(7'b0100000, 3'b000, 5'd4), 32'd3, 32'd5, 3'b110, 32'd5, 32'hFFFF_FFFE, 5'd4, 1, 0);
    run_op("ADDI", {12'hFFF, 5'd1, 3'b000, 5'd5, 7'b0010011}, 32'd1, 32'h1234_5678,
           3'b010, 32'hFFFF_FFFF, 32'd0, 5'd5, 1, 0);
    run_op("AND", enc_r(7'b0000000, 3'b111, 5'd6), 32'h0000_F0F0, 32'h0000_FF00, 3'b000,
           32'h0000_FF00, 32'h0000_F000, 5'd6, 1, 0);
    run_op("OR", enc_r(7'b0000000, 3'b110, 5'd8), 32'h0000_F0F0, 32'h0000_FF00, 3'b001,
           32'h0000_FF00, 32'h0000_FFF0, 5'd8, 1, 0);
    run_op("MUL", enc_r(7'b0000001, 3'b000, 5'd7), 32'd6, 32'd7, 3'b101, 32'd7, 32'd42, 5'd7, 3, 0);
    run_op("ADD bp rd0", enc_r(7'b0000000, 3'b000, 5'd0), 32'hFFFF_FFFF, 32'd3, 3'b010, 32'd3,
           32'd2, 5'd0, 1, 4);

    run_illegal("LOAD", {12'd0, 5'd1, 3'b010, 5'd9, 7'b0000011}, 3'b010);
    run_illegal("bad f7", enc_r(7'b0100001, 3'b000, 5'd9), 3'b010);

    // Reset during the MUL wait drops the pending result.
    @(negedge clk_i);
    inst_valid_i = 1'b1; inst_i = enc_r(7'b0000001, 3'b000, 5'd10);
    rs1_data_i = 32'd9; rs2_data_i = 32'd9;
    @(negedge clk_i);
    inst_valid_i = 1'b0;
    chk("mid mul busy", {31'd0, inst_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("mid rst ready", {31'd0, inst_ready_o}, 32'd1);
    chk("mid rst valid", {31'd0, res_valid_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("after rst no valid", {31'd0, res_valid_o}, 32'd0);
    run_op("ADD post rst", enc_r(7'b0000000, 3'b000, 5'd11), 32'd100, 32'd23, 3'b010, 32'd23,
           32'd123, 5'd11, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
